fp_int_convert: RTL
===================

Name: fp_int_convert

Overview:
- Multi-cycle converter between signed 32-bit integers and IEEE-754 single-precision words.
- Produces the packed float operands that the combinational FP add/sub unit consumes, and unpacks its float results back into integers for the regfile.
- Uses a bit-serial normaliser: one shift per cycle, so area stays small.
- Start/busy/done handshake toward the core control path.

Parameters:
- SAT_EN, 1: 1 = saturating float->int on overflow/NaN/inf; 0 = every invalid case returns 0x80000000.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; accepted only when busy=0
- op  input  1  0 = int->float, 1 = float->int (truncate toward zero)
- src  input  32  operand, captured on the accepting edge
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse; result/flags valid in that cycle and held until the next accept
- result  output  32  converted value
- invalid  output  1  float->int: NaN, inf or out of range
- inexact  output  1  nonzero bits were discarded

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; busy=0, done=0, result=0, invalid=0, inexact=0.
- Reset mid-operation aborts the conversion; no done is ever produced for it.
- FSM states: IDLE -> SHIFT -> IDLE, with done pulsed on the SHIFT->IDLE edge.
- Accept:
  - start=1 && busy=0 at edge T captures op/src and enters SHIFT; busy=1 from T+1.
  - The result/flag registers are cleared on accept.
  - start while busy=1 is ignored.
  - In the done cycle busy=0, so a start in that cycle is accepted (back-to-back operation).
- int->float, at accept:
  - sign = src[31]; mag = |src| as 32-bit unsigned (0x80000000 -> mag 0x80000000); exp = 158.
  - Each SHIFT cycle: if mag==0, result = 0x00000000; else if mag[31]==0, mag <<= 1 and exp -= 1; else pack.
  - Pack: result = {sign, exp[7:0], mag[30:8]}; inexact = |mag[7:0]|. Truncation only, no round-to-nearest.
  - done at T+2+lz, where lz = leading zeros of mag (0..31); zero input gives done at T+2.
- float->int, at accept:
  - Unpack sign, e = src[30:23], acc = {8'b0, 1'b1, src[22:0]}; signed cnt = e - 150.
  - Special cases are resolved in the first SHIFT cycle, with done at T+2:
    - e==255 or e>158, or e==158 with (sign=0 or frac!=0): invalid=1. SAT_EN=1 gives 0x7FFFFFFF for NaN or positive, 0x80000000 for negative; SAT_EN=0 gives 0x80000000.
    - e==158, sign=1, frac==0: result 0x80000000, exact.
    - e<127: result 0; inexact = |src[30:0]|.
  - Otherwise, one step per cycle:
    - cnt<0: acc >>= 1, sticky |= shifted-out bit, cnt += 1.
    - cnt>0: acc <<= 1, cnt -= 1.
    - cnt==0: result = sign ? -acc : acc; inexact = sticky.
  - done at T+2+|e-150|.
- Denormal inputs (e==0) take the e<127 path. Width rules: cnt is 9-bit signed; acc is 32-bit; the shift never overflows on the non-special path.
- Only one op is in flight at a time. done is never asserted in two consecutive cycles for the same op.

Test Plan:
- Directed conversions (start at edge T, SAT_EN=1 unless stated):

| op | src | result | flags | done at |
|---|---|---|---|---|
| i2f | 0x00000001 | 0x3F800000 | inexact=0 | T+33 |
| i2f | 0xFFFFFFFB (-5) | 0xC0A00000 | inexact=0 | T+31 |
| i2f | 0x7FFFFFFF | 0x4EFFFFFF | inexact=1 | T+3 |
| i2f | 0 | 0x00000000 | — | T+2 |
| f2i | 0xC0700000 (-3.75) | 0xFFFFFFFD | inexact=1 | T+24 |
| f2i | 0x3F000000 (0.5) | 0 | inexact=1 | T+2 |
| f2i | 0x7F800000 (+inf), SAT_EN=1 | 0x7FFFFFFF | invalid=1 | T+2 |
| f2i | 0x7F800000 (+inf), SAT_EN=0 | 0x80000000 | invalid=1 | — |
| f2i | 0xCF000000 | 0x80000000 | invalid=0, inexact=0 | T+2 |

- Handshake:
  - start held high during an i2f of 1 → the op is ignored until the done cycle.
  - A start in the done cycle is accepted → the next result is correct.
- Reset: rst_n=0 at T+10 of an i2f of 1 → busy=0, all outputs 0, and no done in the following 40 cycles.

Source files
------------

// File: rtl/fp_int_convert.sv
// ---------------------------------------------------------------------------
// fp_int_convert
//   Multi-cycle converter between signed 32-bit integers and IEEE-754 single
//   precision words. A bit-serial normaliser moves the working mantissa one
//   position per cycle, so a conversion takes a data-dependent number of
//   cycles. Only one conversion is in flight at a time.
//
// Parameters
//   SAT_EN  1: float->int overflow/NaN/inf saturates (NaN or positive gives
//              0x7FFFFFFF, negative gives 0x80000000)
//           0: every invalid float->int case gives 0x80000000
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset
//   start    in   conversion request, accepted only while busy=0
//   op       in   0 = int->float, 1 = float->int (truncate toward zero)
//   src      in   operand, captured on the accepting edge
//   busy     out  conversion in progress
//   done     out  one-cycle pulse; result/flags valid from then until the
//                 next accept
//   result   out  converted value
//   invalid  out  float->int: NaN, inf or out of range
//   inexact  out  nonzero bits were discarded
// ---------------------------------------------------------------------------
module fp_int_convert #(
   parameter bit SAT_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        op,
   input  logic [31:0] src,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        invalid,
   output logic        inexact
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   localparam logic OP_I2F = 1'b0;

   state_t             state_q,   state_d;
   logic               op_q,      op_d;
   logic               sign_q,    sign_d;
   // mag_q: integer magnitude (int->float) or mantissa accumulator (float->int)
   logic [31:0]        mag_q,     mag_d;
   // exp_q: running exponent (int->float) or captured biased exponent (float->int)
   logic [7:0]         exp_q,     exp_d;
   logic signed [8:0]  cnt_q,     cnt_d;
   logic               sticky_q,  sticky_d;
   logic               first_q,   first_d;
   logic               busy_q,    busy_d;
   logic               done_q,    done_d;
   logic [31:0]        result_q,  result_d;
   logic               invalid_q, invalid_d;
   logic               inexact_q, inexact_d;

   // Float->int special-case decode, meaningful in the first SHIFT cycle while
   // exp_q/mag_q[22:0] still hold the unmodified exponent and fraction.
   logic               frac_nz_s;
   logic               f_invalid_s;
   logic               f_nan_s;
   logic               f_minint_s;
   logic               f_small_s;
   logic [31:0]        f_sat_val_s;

   // Two's-complement magnitude; 0x80000000 maps onto itself as unsigned.
   function automatic logic [31:0] abs32(input logic [31:0] v);
      logic [31:0] r;
      if (v[31]) begin
         r = ~v + 32'd1;
      end else begin
         r = v;
      end
      return r;
   endfunction

   // Decode float->int special operands from the captured fields.
   always_comb begin
      frac_nz_s   = (mag_q[22:0] != 23'd0);
      f_nan_s     = (exp_q == 8'd255) && frac_nz_s;
      f_invalid_s = (exp_q > 8'd158) ||
                    ((exp_q == 8'd158) && (!sign_q || frac_nz_s));
      f_minint_s  = (exp_q == 8'd158) && sign_q && !frac_nz_s;
      f_small_s   = (exp_q < 8'd127);
      if (SAT_EN) begin
         if (f_nan_s || !sign_q) begin
            f_sat_val_s = 32'h7FFF_FFFF;
         end else begin
            f_sat_val_s = 32'h8000_0000;
         end
      end else begin
         f_sat_val_s = 32'h8000_0000;
      end
   end

   // Next-state and datapath control for the accept / shift sequence.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      sign_d    = sign_q;
      mag_d     = mag_q;
      exp_d     = exp_q;
      cnt_d     = cnt_q;
      sticky_d  = sticky_q;
      first_d   = first_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      result_d  = result_q;
      invalid_d = invalid_q;
      inexact_d = inexact_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_SHIFT;
               busy_d    = 1'b1;
               op_d      = op;
               sign_d    = src[31];
               first_d   = 1'b1;
               sticky_d  = 1'b0;
               result_d  = 32'd0;
               invalid_d = 1'b0;
               inexact_d = 1'b0;
               if (op == OP_I2F) begin
                  mag_d = abs32(src);
                  exp_d = 8'd158;
                  cnt_d = 9'sd0;
               end else begin
                  mag_d = {8'd0, 1'b1, src[22:0]};
                  exp_d = src[30:23];
                  cnt_d = $signed({1'b0, src[30:23]}) - 9'sd150;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_SHIFT: begin
            first_d = 1'b0;
            if (op_q == OP_I2F) begin
               if (mag_q == 32'd0) begin
                  result_d = 32'd0;
                  state_d  = ST_IDLE;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
               end else if (!mag_q[31]) begin
                  mag_d = {mag_q[30:0], 1'b0};
                  exp_d = exp_q - 8'd1;
               end else begin
                  // Truncating pack: the low 8 magnitude bits are dropped.
                  result_d  = {sign_q, exp_q, mag_q[30:8]};
                  inexact_d = (mag_q[7:0] != 8'd0);
                  state_d   = ST_IDLE;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
               end
            end else begin
               if (first_q && f_invalid_s) begin
                  result_d  = f_sat_val_s;
                  invalid_d = 1'b1;
                  state_d   = ST_IDLE;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
               end else if (first_q && f_minint_s) begin
                  result_d = 32'h8000_0000;
                  state_d  = ST_IDLE;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
               end else if (first_q && f_small_s) begin
                  // |value| < 1 truncates to zero; any nonzero encoding is inexact.
                  result_d  = 32'd0;
                  inexact_d = (exp_q != 8'd0) || frac_nz_s;
                  state_d   = ST_IDLE;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
               end else if (cnt_q < 9'sd0) begin
                  mag_d    = {1'b0, mag_q[31:1]};
                  sticky_d = sticky_q | mag_q[0];
                  cnt_d    = cnt_q + 9'sd1;
               end else if (cnt_q > 9'sd0) begin
                  mag_d = {mag_q[30:0], 1'b0};
                  cnt_d = cnt_q - 9'sd1;
               end else begin
                  if (sign_q) begin
                     result_d = ~mag_q + 32'd1;
                  end else begin
                     result_d = mag_q;
                  end
                  inexact_d = sticky_q;
                  state_d   = ST_IDLE;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         op_q      <= 1'b0;
         sign_q    <= 1'b0;
         mag_q     <= 32'd0;
         exp_q     <= 8'd0;
         cnt_q     <= 9'sd0;
         sticky_q  <= 1'b0;
         first_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= 32'd0;
         invalid_q <= 1'b0;
         inexact_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         sign_q    <= sign_d;
         mag_q     <= mag_d;
         exp_q     <= exp_d;
         cnt_q     <= cnt_d;
         sticky_q  <= sticky_d;
         first_q   <= first_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         result_q  <= result_d;
         invalid_q <= invalid_d;
         inexact_q <= inexact_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign result  = result_q;
   assign invalid = invalid_q;
   assign inexact = inexact_q;

endmodule
